// File: rtl/mux_2to1.sv
// Single-bit 2:1 select; the arbiter replicates it across the payload width.
module mux_2to1 (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/rr_arb_2to1.sv
// Two-input round-robin arbiter feeding a single registered output slot.
// Contending inputs alternate; a stalled output freezes arbitration history.
module rr_arb_2to1 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             out_src
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    out_state_e       state_q, state_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_src_q, out_src_d;
    logic             last_grant_q, last_grant_d;

    logic             grant_valid_s;
    logic             grant_idx_s;
    logic             can_load_s;
    logic             load_s;
    logic [WIDTH-1:0] sel_data_s;

    // Grant selection: lone requester wins, contention goes to the input not served last.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = 1'b0;
        case ({in1_valid, in0_valid})
            2'b01:   begin grant_valid_s = 1'b1; grant_idx_s = 1'b0;          end
            2'b10:   begin grant_valid_s = 1'b1; grant_idx_s = 1'b1;          end
            2'b11:   begin grant_valid_s = 1'b1; grant_idx_s = ~last_grant_q; end
            default: begin grant_valid_s = 1'b0; grant_idx_s = 1'b0;          end
        endcase
    end

    // Ready generation; rst_n gates both readys so nothing is accepted during reset.
    always_comb begin
        can_load_s = (state_q == ST_EMPTY) || out_ready;
        load_s     = rst_n && can_load_s && grant_valid_s;
        in0_ready  = load_s && (grant_idx_s == 1'b0);
        in1_ready  = load_s && (grant_idx_s == 1'b1);
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_sel_mux
        mux_2to1 u_mux (
            .a   (in0_data[i]),
            .b   (in1_data[i]),
            .sel (grant_idx_s),
            .y   (sel_data_s[i])
        );
    end

    // Output slot next-state: load on transfer, drain when consumed, otherwise hold.
    always_comb begin
        state_d      = state_q;
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        last_grant_d = last_grant_q;
        if (load_s) begin
            state_d      = ST_FULL;
            out_data_d   = sel_data_s;
            out_src_d    = grant_idx_s;
            last_grant_d = grant_idx_s;
        end else if ((state_q == ST_FULL) && out_ready) begin
            state_d = ST_EMPTY;
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers; last_grant resets to 1 so in0 wins the first contention.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            out_data_q   <= {WIDTH{1'b0}};
            out_src_q    <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule
